// File: rtl/csr_cmd_queue_bridge.sv
// csr_cmd_queue_bridge: queues CSR-submitted variable-length commands and drains them word by word into the engine command FIFO.
// Latency: submit edge sampled in cycle 0 -> queued in cycle 1 -> first push in cycle 2; N words take N cycles unstalled.
// Backpressure: i_fifo_full stalls the current word in place; i_fifo_afull only holds off the start of a new command.
module csr_cmd_queue_bridge #(
  parameter int DATA_W      = 32,
  parameter int MAX_WORDS   = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter bit USE_AFULL   = 1'b1,
  parameter int LEN_W       = $clog2(MAX_WORDS + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic [MAX_WORDS*DATA_W-1:0]        i_cmd_words,
  input  logic [LEN_W-1:0]                   i_cmd_len,
  input  logic                               i_cmd_submit,
  input  logic                               i_clear_err,
  output logic                               o_bridge_busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_queue_count,
  output logic                               o_queue_full,
  output logic [15:0]                        o_submit_cnt,
  output logic [15:0]                        o_drop_cnt,
  output logic                               o_overflow,
  output logic [DATA_W-1:0]                  o_fifo_wdata,
  output logic                               o_fifo_wen,
  input  logic                               i_fifo_full,
  input  logic                               i_fifo_afull
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PUSH = 1'b1
  } state_e;

  // Command storage: one slot per queued command, words kept unpacked for direct indexing
  logic [DATA_W-1:0] words_q [QUEUE_DEPTH][MAX_WORDS];
  logic [LEN_W-1:0]  len_q   [QUEUE_DEPTH];

  // Control state
  logic              submit_prev_q;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       submit_cnt_q, submit_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  // Combinational helpers
  logic              submit_pulse;
  logic              len_zero;
  logic [LEN_W-1:0]  len_clamped;
  logic              queue_full;
  logic              afull_gate;
  logic [LEN_W-1:0]  head_len;
  logic              last_word;
  logic              push;
  logic              pop;
  logic              reject;
  logic              fifo_wen;
  logic [DATA_W-1:0] fifo_wdata;

  // Only the rising edge of the level-style submit strobe acts
  assign submit_pulse = i_cmd_submit & ~submit_prev_q;

  // Oversized lengths are clamped rather than rejected; zero length is always rejected
  assign len_zero    = (i_cmd_len == '0);
  assign len_clamped = (i_cmd_len > MAX_LEN) ? MAX_LEN : i_cmd_len;

  assign queue_full = (count_q == FULL_CNT);

  // Almost-full only gates the start of a command, never a command already in flight
  assign afull_gate = !(USE_AFULL && i_fifo_afull);

  assign head_len  = len_q[head_q];
  assign last_word = (LEN_W'(idx_q) == (head_len - LEN_W'(1)));

  // A full queue still accepts when the head pops this cycle: the freed slot is the tail slot
  assign push   = submit_pulse && !len_zero && (!queue_full || pop);
  assign reject = submit_pulse && !push;

  // FSM outputs: present the current head word while pushing, drive zeros while idle
  always_comb begin
    fifo_wen   = 1'b0;
    fifo_wdata = '0;
    pop        = 1'b0;
    if (state_q == ST_PUSH) begin
      fifo_wen   = !i_fifo_full;
      fifo_wdata = words_q[head_q][idx_q];
      pop        = fifo_wen && last_word;
    end
  end

  // Queue pointer and occupancy update; simultaneous push and pop keep the count
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM next state: start on non-empty queue with gate open, chain commands without a bubble
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && afull_gate) begin
          state_d = ST_PUSH;
          idx_d   = '0;
        end
      end
      ST_PUSH: begin
        if (fifo_wen) begin
          if (last_word) begin
            idx_d   = '0;
            state_d = ((count_d != '0) && afull_gate) ? ST_PUSH : ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Accept/drop statistics; a clear wins over a same-cycle reject
  always_comb begin
    submit_cnt_d = push ? (submit_cnt_q + 16'd1) : submit_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    if (i_clear_err) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (reject) begin
      drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : (drop_cnt_q + 16'd1);
      overflow_d = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Queue control and counters; reset abandons any partial command and empties the queue
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      submit_prev_q <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      submit_cnt_q  <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      submit_prev_q <= i_cmd_submit;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      submit_cnt_q  <= submit_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  // Payload storage: written on accept only, contents are don't-care until a slot is filled
  always_ff @(posedge i_clk) begin
    if (push) begin
      len_q[tail_q] <= len_clamped;
      for (int k = 0; k < MAX_WORDS; k++) begin
        words_q[tail_q][k] <= i_cmd_words[k*DATA_W +: DATA_W];
      end
    end
  end

  assign o_bridge_busy = (count_q != '0) || (state_q == ST_PUSH);
  assign o_queue_count = count_q;
  assign o_queue_full  = queue_full;
  assign o_submit_cnt  = submit_cnt_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_overflow    = overflow_q;
  assign o_fifo_wen    = fifo_wen;
  assign o_fifo_wdata  = fifo_wdata;

endmodule
